encoder_8to3: RTL and testbench
===============================

Name: encoder_8to3

Overview:
Registered 8-to-3 priority encoder. Encodes the index of the highest-priority asserted bit of an 8-bit request vector into a 3-bit code with a valid flag, plus status flags for one-hot and multi-hot input. Used as a request-to-index stage in front of arbiters or muxes; outputs are registered so they can drive downstream logic directly.

Parameters:
- PRIORITY_MSB, default 1: 1 = highest set bit wins; 0 = lowest set bit wins.
- Input width fixed at 8 and output width fixed at 3; not parameterised.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- en  input  1  sample enable; when 1, outputs update from in on this edge.
- in  input  8  request vector; bit i requests index i.
- out  output  3  encoded index of the winning bit (registered).
- valid  output  1  1 when at least one bit of the sampled in was set (registered).
- onehot  output  1  1 when exactly one bit of the sampled in was set (registered).
- multi  output  1  1 when two or more bits of the sampled in were set (registered).

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: on a rising edge with rst_n=0, out=3'b000, valid=0, onehot=0, multi=0, whatever en and in are. Reset overrides en.
- Latency: 1 cycle. A value of in sampled on edge N, with en=1 and rst_n=1, appears on all outputs after edge N.
- en=0 with rst_n=1: all outputs hold their previous values.
- Encoding with PRIORITY_MSB=1: out = index of the highest set bit. Examples:
  - 8'b00000001 -> 000
  - 8'b10000000 -> 111
  - 8'b11111111 -> 111
  - 8'b00010110 -> 100
- Encoding with PRIORITY_MSB=0: out = index of the lowest set bit. Example: 8'b11111111 -> 000.
- in = 8'b00000000: out=000, valid=0, onehot=0, multi=0. out=000 is indistinguishable from index 0 except through valid, so consumers must qualify out with valid.
- Flag invariants, which hold on every cycle:
  - valid = onehot | multi.
  - onehot and multi are never both 1.
  - valid=0 implies out=000.
- Combinational path: from in to the register D inputs only. No combinational path from in or en to any output.
- No X propagation. Outputs are fully defined for every input value after the first reset. Before the first reset, output values are unspecified.
- Reset mid-stream: a reset edge clears the outputs, and the in value presented on that edge is discarded. The first sample after reset is taken on the next edge with rst_n=1 and en=1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in=8'hFF and en=1 -> out=000, valid=0, onehot=0, multi=0. Release rst_n, keep in=8'hFF -> after 1 edge: out=111, valid=1, onehot=0, multi=1.
- Walking one: en=1, in=00000000 followed by 00000001 through 10000000, one value per cycle -> outputs lag by 1 cycle:
  - 00000000 gives out=000, valid=0.
  - each 1<<i gives out=i, valid=1, onehot=1, multi=0.
- Priority (PRIORITY_MSB=1):
  - in=8'b00010110 -> out=100, multi=1.
  - in=8'b11111111 -> out=111, valid=1, multi=1.
  - in=8'b01000001 -> out=110.
- Hold: load in=8'b00001000 (out=011). Then set en=0 and change in to 8'b10000000 for 3 cycles -> out stays 011, valid=1, onehot=1. Raise en -> next cycle out=111.
- Priority (PRIORITY_MSB=0 instance): in=8'b11111111 -> out=000, valid=1, multi=1. in=8'b10100000 -> out=101.
- Reset mid-stream: while streaming random vectors with en=1, assert rst_n=0 for one edge -> outputs all 0 after that edge. Next edge with rst_n=1 resumes correct encoding. Over 1000 random vectors, check every output against a reference model and check all flag invariants.

Source files
------------

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid, one-hot and multi-hot flags.
// PRIORITY_MSB selects whether the highest (1) or lowest (0) set bit wins.
module encoder_8to3 #(
  parameter int unsigned PRIORITY_MSB = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  output logic       onehot,
  output logic       multi
);

  logic [2:0] idx_d;
  logic [3:0] cnt_d;
  logic [2:0] out_q;
  logic       valid_q;
  logic       onehot_q;
  logic       multi_q;

  // Scan order makes the last matching bit the winner; idx_d stays 0 for an empty vector.
  always_comb begin
    idx_d = 3'd0;
    cnt_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_d = cnt_d + {3'd0, in[i]};
    end
    if (PRIORITY_MSB != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (in[i]) idx_d = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (in[i]) idx_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= 3'd0;
      valid_q  <= 1'b0;
      onehot_q <= 1'b0;
      multi_q  <= 1'b0;
    end else if (en) begin
      out_q    <= idx_d;
      valid_q  <= (cnt_d != 4'd0);
      onehot_q <= (cnt_d == 4'd1);
      multi_q  <= (cnt_d > 4'd1);
    end
  end

  assign out    = out_q;
  assign valid  = valid_q;
  assign onehot = onehot_q;
  assign multi  = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Scoreboard bench for encoder_8to3: MSB- and LSB-priority instances share stimulus;
// a reference model queues expected outputs, a monitor pops and compares each cycle.
module tb_encoder_8to3;

  typedef struct packed {
    logic [2:0] out;
    logic       valid;
    logic       onehot;
    logic       multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = 8'd0;

  logic [2:0] out_m, out_l;
  logic       valid_m, valid_l, onehot_m, onehot_l, multi_m, multi_l;

  int vectors = 0;
  int miscompares = 0;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t st_m = '0;
  exp_t st_l = '0;

  always #5 clk = ~clk;

  encoder_8to3 #(.PRIORITY_MSB(1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (din),
    .out   (out_m),
    .valid (valid_m),
    .onehot(onehot_m),
    .multi (multi_m)
  );

  encoder_8to3 #(.PRIORITY_MSB(0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (din),
    .out   (out_l),
    .valid (valid_l),
    .onehot(onehot_l),
    .multi (multi_l)
  );

  // Highest set bit = floor(log2 v); lowest set bit = log2 of the isolated low bit.
  function automatic exp_t ref_model(input logic [7:0] v, input bit msb);
    exp_t r;
    int   n;
    int   vi;
    int   idx;
    r  = '0;
    n  = $countones(v);
    vi = int'(v);
    if (n == 0) return r;
    if (msb) idx = $clog2(vi + 1) - 1;
    else     idx = $clog2(vi & -vi);
    r.out    = 3'(idx);
    r.valid  = 1'b1;
    r.onehot = (n == 1);
    r.multi  = (n > 1);
    return r;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [7:0] v);
    @(negedge clk);
    rst_n = r;
    en    = e;
    din   = v;
    if (!r) begin
      st_m = '0;
      st_l = '0;
    end else if (e) begin
      st_m = ref_model(v, 1'b1);
      st_l = ref_model(v, 1'b0);
    end
    q_m.push_back(st_m);
    q_l.push_back(st_l);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic [2:0] o, input logic v,
                           input logic oh, input logic mh);
    check({tag, ".out"}, o, e.out);
    check({tag, ".valid"}, {2'b0, v}, {2'b0, e.valid});
    check({tag, ".onehot"}, {2'b0, oh}, {2'b0, e.onehot});
    check({tag, ".multi"}, {2'b0, mh}, {2'b0, e.multi});
    check({tag, ".inv_valid"}, {2'b0, v}, {2'b0, oh | mh});
    check({tag, ".inv_excl"}, {2'b0, oh & mh}, 3'd0);
    if (v === 1'b0) check({tag, ".inv_out0"}, o, 3'd0);
  endtask

  // Monitor: registered outputs settle just after each rising edge.
  initial begin
    exp_t em, el;
    forever begin
      @(posedge clk);
      #1;
      if (q_m.size() > 0) begin
        em = q_m.pop_front();
        el = q_l.pop_front();
        check_dut("msb", em, out_m, valid_m, onehot_m, multi_m);
        check_dut("lsb", el, out_l, valid_l, onehot_l, multi_l);
      end
    end
  end

  initial begin
    logic [7:0] v;
    // Reset with aggressive inputs, then release.
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF);
    // Walking one.
    drive(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'(1 << i));
    // Priority patterns.
    drive(1'b1, 1'b1, 8'b0001_0110);
    drive(1'b1, 1'b1, 8'b1111_1111);
    drive(1'b1, 1'b1, 8'b0100_0001);
    drive(1'b1, 1'b1, 8'b1010_0000);
    // Hold.
    drive(1'b1, 1'b1, 8'b0000_1000);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'b1000_0000);
    drive(1'b1, 1'b1, 8'b1000_0000);
    // Random stream with occasional enable gaps and mid-stream resets.
    for (int i = 0; i < 1000; i++) begin
      v = 8'($urandom);
      if (i == 300 || i == 700 || $urandom_range(0, 63) == 0) drive(1'b0, 1'b1, v);
      else drive(1'b1, ($urandom_range(0, 7) != 0), v);
    end
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    vectors++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", q_m.size(), q_l.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
